om_mult_serial: RTL

Parametrised, fully sequential radix-2 online (MSD-first) multiplier for signed-digit operands. It accepts one digit of each operand per step and emits one product digit per step after an online delay of 3, over a run-time-free, compile-time-fixed precision of N digits. It replaces the hand-unrolled per-stage multiplier slices with a single iterative datapath. The datapath holds its own operand registers (on-the-fly converted), carry-save residual, selection logic and valid/ready handshakes on both sides.

---
 rtl/om_mult_serial.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/om_mult_serial.sv
// om_mult_serial: radix-2 MSD-first online multiplier, delay 3, N digits.
// Digits {p,n}: 10=+1, 01=-1. Optional two's-complement output: OM_MULT_TC_EN.
// Ports: clk, rst_n (async, active low); in_valid/in_ready with x, y;
// out_valid/out_ready with z, out_last; busy; z_tc, z_tc_valid.
module om_mult_serial #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] z,
  output logic       out_last,
  output logic       busy,
  output logic [N:0] z_tc,
  output logic       z_tc_valid
);
  localparam int WW = N + 5;
  localparam int CW = $clog2(N + 4);
  localparam logic [N:0] QM0 = {1'b1, {N{1'b0}}};
  localparam logic [N:0] M0 = {2'b01, {(N-1){1'b0}}};
  localparam logic [CW-1:0] C_LD = CW'(2);
  localparam logic [CW-1:0] C_R0 = CW'(3);
  localparam logic [CW-1:0] C_RE = CW'(N - 1);
  localparam logic [CW-1:0] C_LAST = CW'(N + 2);

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN, FLUSH, DRAIN
  } state_t;

  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [N:0] xq, xqm, yq, yqm, msk;
  logic [N:0] xq_nx, xqm_nx, yq_nx, yqm_nx;
  logic [WW-1:0] ws, wc;
  logic [WW-1:0] ya, xb, ta, tb, p, q;
  logic [WW-1:0] s1, m1, c1, s2, m2, c2;
  logic [1:0] xd, yd, wtop;
  logic [4:0] vh;
  logic xp, xn, yp, yn;
  logic sel, zpos, zneg;
  logic slot_free, consume, step, clr;
  logic unused;

  assign slot_free = !out_valid || out_ready;
  assign consume = out_valid && out_ready;
  assign in_ready = rst_n &&
    (state == IDLE || state == LOAD ||
     (state == RUN && slot_free));
  assign step = (in_valid && in_ready) ||
    (state == FLUSH && slot_free);
  assign clr = (state == DRAIN) && consume;
  assign sel = (state == RUN) || (state == FLUSH);
  assign busy = (state != IDLE);

  assign xd = (state == FLUSH) ? 2'b00 : x;
  assign yd = (state == FLUSH) ? 2'b00 : y;
  assign xp = (xd == 2'b10);
  assign xn = (xd == 2'b01);
  assign yp = (yd == 2'b10);
  assign yn = (yd == 2'b01);

  always_comb begin
    yq_nx = yq;
    yqm_nx = yqm;
    unique case (1'b1)
      yp: begin
        yq_nx = yq | msk;
        yqm_nx = yq;
      end
      yn: begin
        yq_nx = yqm | msk;
        yqm_nx = yqm;
      end
      default: yqm_nx = yqm | msk;
    endcase
  end

  always_comb begin
    xq_nx = xq;
    xqm_nx = xqm;
    unique case (1'b1)
      xp: begin
        xq_nx = xq | msk;
        xqm_nx = xq;
      end
      xn: begin
        xq_nx = xqm | msk;
        xqm_nx = xqm;
      end
      default: xqm_nx = xqm | msk;
    endcase
  end

  // Y is taken after its update, X before its update.
  assign ya = {{4{yq_nx[N]}}, yq_nx};
  assign xb = {{4{xq[N]}}, xq};
  assign ta = xp ? ya : (xn ? ~ya : '0);
  assign tb = yp ? xb : (yn ? ~xb : '0);

  // 4:2 CSA; the free LSBs of the carry vectors take the +1 of negation.
  assign p = {ws[WW-2:0], 1'b0};
  assign q = {wc[WW-2:0], 1'b0};
  assign s1 = p ^ q ^ ta;
  assign m1 = (p & q) | (p & ta) | (q & ta);
  assign c1 = {m1[WW-2:0], xn};
  assign s2 = s1 ^ c1 ^ tb;
  assign m2 = (s1 & c1) | (s1 & tb) | (c1 & tb);
  assign c2 = {m2[WW-2:0], yn};

  // Estimate keeps a third fraction bit so that the largest step-0
  // residual cannot alias across the +2/-2 wrap of the estimate.
  assign vh = s2[WW-1:WW-5] + c2[WW-1:WW-5];
  assign zpos = sel && ($signed(vh) >= 5'sd4);
  assign zneg = sel && ($signed(vh) < -5'sd4);
  assign wtop = s2[WW-1:WW-2] +
    (zpos ? 2'b11 : (zneg ? 2'b01 : 2'b00));

  assign unused = ^{ws[WW-1], wc[WW-1], m1[WW-1], m2[WW-1]};

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (step) state_nx = LOAD;
      LOAD:  if (step && cnt == C_LD) state_nx = RUN;
      RUN:   if (step && cnt == C_RE) state_nx = FLUSH;
      FLUSH: if (step && cnt == C_LAST) state_nx = DRAIN;
      DRAIN: if (consume) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      xq <= '0;
      xqm <= QM0;
      yq <= '0;
      yqm <= QM0;
      msk <= M0;
      ws <= '0;
      wc <= '0;
      out_valid <= 1'b0;
      z <= 2'b00;
      out_last <= 1'b0;
    end else begin
      state <= state_nx;
      if (step) begin
        cnt <= cnt + 1'b1;
        xq <= xq_nx;
        xqm <= xqm_nx;
        yq <= yq_nx;
        yqm <= yqm_nx;
        msk <= msk >> 1;
        ws <= {wtop, s2[WW-3:0]};
        wc <= c2;
      end else if (clr) begin
        cnt <= '0;
        xq <= '0;
        xqm <= QM0;
        yq <= '0;
        yqm <= QM0;
        msk <= M0;
        ws <= '0;
        wc <= '0;
      end
      if (step && sel) begin
        out_valid <= 1'b1;
        z <= {zpos, zneg};
        out_last <= (cnt == C_LAST);
      end else if (consume) begin
        out_valid <= 1'b0;
        out_last <= 1'b0;
      end
    end
  end

`ifdef OM_MULT_TC_EN
  logic [N:0] zq, zqm, zmsk, zb_q, zb_qm, zb_m;
  logic zfirst;

  // The first product digit restarts the converter.
  assign zfirst = (cnt == C_R0);
  assign zb_q = zfirst ? '0 : zq;
  assign zb_qm = zfirst ? QM0 : zqm;
  assign zb_m = zfirst ? M0 : zmsk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zq <= '0;
      zqm <= QM0;
      zmsk <= M0;
    end else if (step && sel) begin
      zmsk <= zb_m >> 1;
      unique case (1'b1)
        zpos: begin
          zq <= zb_q | zb_m;
          zqm <= zb_q;
        end
        zneg: begin
          zq <= zb_qm | zb_m;
          zqm <= zb_qm;
        end
        default: begin
          zq <= zb_q;
          zqm <= zb_qm | zb_m;
        end
      endcase
    end
  end

  assign z_tc = zq;
  assign z_tc_valid = clr;
`else
  assign z_tc = '0;
  assign z_tc_valid = 1'b0;
`endif

endmodule
